// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - I/D cacheline memory port arbiter (optional ARB_ROUND_ROBIN_EN)
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_busy
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_write;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D owned the most recent grant, 0 = I
  logic last_grant;

  // On a conflict the requester that did not win last time is granted
  assign grant_d = d_req  && !(i_read && last_grant);
  assign grant_i = i_read && !(d_req && !last_grant);

  // Remember the owner of every grant issued from IDLE
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (state == IDLE && grant_d)
      last_grant <= 1'b1;
    else if (state == IDLE && grant_i)
      last_grant <= 1'b0;
  end
`else
  // Fixed priority: D-cache always wins a conflict
  assign grant_d = d_req;
  assign grant_i = i_read && !d_req;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Capture the winner's request at grant time; later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else if (state == IDLE && grant_d) begin
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_write <= d_write;
    end else if (state == IDLE && grant_i) begin
      lat_addr  <= i_addr;
      lat_write <= 1'b0;
    end
  end

  // Next-state, memory request strobes and response routing to the owner
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d)
          state_next = GRANT_D;
        else if (grant_i)
          state_next = GRANT_I;
      end
      GRANT_I: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          i_resp     = !rst;
          state_next = DONE;
        end
      end
      GRANT_D: begin
        mem_read  = !lat_write;
        mem_write = lat_write;
        if (mem_resp) begin
          d_resp     = !rst;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign arb_busy  = (state != IDLE);

`ifndef SYNTHESIS
  // A D-cache read and writeback at once is illegal; the write is taken
  always @(posedge clk) begin
    if (!rst)
      assert (!(d_read && d_write)) else $error("d_read and d_write asserted together");
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          arb_busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          is_d;
    logic [LW-1:0] data;
  } exp_t;
  exp_t sb[$];

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected completion, then present a one-cycle memory response
  task automatic do_resp(input logic is_d, input logic [LW-1:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
    mem_resp  = 1'b1;
    mem_rdata = data;
    tick();
    mem_resp  = 1'b0;
  endtask

  // Monitor: every resp pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (i_resp === 1'b1 || d_resp === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_owner", {254'd0, d_resp, i_resp}, {254'd0, e.is_d, !e.is_d});
        check("resp_data", e.is_d ? d_rdata : i_rdata, e.data);
      end
    end
  end

  initial begin
    logic          first_d;
    logic [AW-1:0] first_addr, second_addr;
    rst = 1'b1; i_read = 0; i_addr = '0; d_read = 0; d_write = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
    tick(); tick();
    check("rst_busy", {255'd0, arb_busy}, '0);
    check("rst_mem_read", {255'd0, mem_read}, '0);
    check("rst_mem_write", {255'd0, mem_write}, '0);
    check("rst_mem_addr", {224'd0, mem_addr}, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_resp", {254'd0, d_resp, i_resp}, '0);
    rst = 1'b0;
    tick();

    // Isolated I read
    i_read = 1; i_addr = 32'h0000_1040;
    tick();
    check("i_mem_read", {255'd0, mem_read}, 256'd1);
    check("i_mem_write", {255'd0, mem_write}, '0);
    check("i_mem_addr", {224'd0, mem_addr}, 256'h1040);
    check("i_busy", {255'd0, arb_busy}, 256'd1);
    tick(); tick();
    do_resp(1'b0, {32{8'hA5}});
    i_read = 0;
    check("i_done_busy", {255'd0, arb_busy}, 256'd1);
    check("i_done_mem_read", {255'd0, mem_read}, '0);
    tick();
    check("i_idle_busy", {255'd0, arb_busy}, '0);

    // D writeback
    d_write = 1; d_addr = 32'h8000_0200; d_wdata = {8{32'h1234_5678}};
    tick();
    check("dw_mem_write", {255'd0, mem_write}, 256'd1);
    check("dw_mem_read", {255'd0, mem_read}, '0);
    check("dw_mem_addr", {224'd0, mem_addr}, 256'h8000_0200);
    check("dw_mem_wdata", mem_wdata, {8{32'h1234_5678}});
    tick();
    do_resp(1'b1, {8{32'h0BAD_F00D}});
    d_write = 0;
    tick();

    // Conflict: both requests rise together
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    first_addr  = first_d ? 32'h0000_3000 : 32'h0000_2000;
    second_addr = first_d ? 32'h0000_2000 : 32'h0000_3000;
    i_read = 1; i_addr = 32'h0000_2000; d_read = 1; d_addr = 32'h0000_3000;
    tick();
    check("cf1_mem_addr", {224'd0, mem_addr}, {224'd0, first_addr});
    check("cf1_mem_read", {255'd0, mem_read}, 256'd1);
    tick();
    do_resp(first_d, {4{64'h1111_2222_3333_4444}});
    if (first_d) d_read = 0; else i_read = 0;
    tick();
    check("cf_gap_busy", {255'd0, arb_busy}, '0);
    check("cf_gap_mem_read", {255'd0, mem_read}, '0);
    tick();
    check("cf2_mem_addr", {224'd0, mem_addr}, {224'd0, second_addr});
    check("cf2_mem_read", {255'd0, mem_read}, 256'd1);
    do_resp(!first_d, {4{64'h5555_6666_7777_8888}});
    i_read = 0; d_read = 0;
    tick();

    // D request inputs change while granted
    d_read = 1; d_addr = 32'h4000_0100; d_wdata = {8{32'hCAFE_BABE}};
    tick();
    d_addr = 32'hDEAD_0000; d_wdata = {8{32'hFFFF_FFFF}};
    tick();
    check("hold_mem_addr", {224'd0, mem_addr}, 256'h4000_0100);
    check("hold_mem_read", {255'd0, mem_read}, 256'd1);
    tick();
    do_resp(1'b1, {16{16'h9C3E}});
    d_read = 0;
    tick();

    // Reset in GRANT_I with a response arriving alongside it
    i_read = 1; i_addr = 32'h0000_5000;
    tick();
    check("rg_mem_read", {255'd0, mem_read}, 256'd1);
    rst = 1; mem_resp = 1; mem_rdata = {8{32'h7777_7777}}; i_read = 0;
    tick();
    check("rg_mem_read_after", {255'd0, mem_read}, '0);
    check("rg_busy_after", {255'd0, arb_busy}, '0);
    check("rg_i_resp_after", {255'd0, i_resp}, '0);
    // Stray response while IDLE
    rst = 0;
    tick();
    check("stray_busy", {255'd0, arb_busy}, '0);
    check("stray_resp", {254'd0, d_resp, i_resp}, '0);
    mem_resp = 0;
    tick(); tick();
    check("sb_empty", 256'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory cacheline port between the I-cache miss path and the D-cache miss/writeback path of the pipelined RV32I core.
- Sits between the two caches and the cacheline adaptor.
- A registered FSM grants one requester at a time and latches its address and write data.
- It forwards the transaction to memory and routes the one-cycle response back to the owner.

Parameters:
ADDR_W, 32, byte address width of all request ports
LINE_W, 256, cacheline data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line data to I-cache, valid when i_resp=1
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line writeback request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache writeback data
d_rdata  out  LINE_W  line data to D-cache, valid when d_resp=1
d_resp  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  read request to cacheline adaptor
mem_write  out  1  write request to cacheline adaptor
mem_addr  out  ADDR_W  latched address of granted requester
mem_wdata  out  LINE_W  latched writeback data
mem_rdata  in  LINE_W  line data from adaptor
mem_resp  in  1  one-cycle completion pulse from adaptor
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - i_resp=0, d_resp=0, arb_busy=0.
  - i_rdata and d_rdata are don't-care while the matching resp=0.
- States: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE:
  - mem_read=0, mem_write=0.
  - If a D request (d_read|d_write) is pending, latch d_addr/d_wdata/op and go to GRANT_D.
  - Otherwise, if i_read is pending, latch i_addr and go to GRANT_I.
  - Fixed D priority applies without the macro.
- GRANT_I:
  - mem_read=1, mem_write=0; mem_addr is the latched address.
  - On mem_resp: i_resp=1 and i_rdata=mem_rdata in the same cycle (combinational), then go to DONE.
- GRANT_D:
  - mem_read or mem_write follows the latched op; mem_addr and mem_wdata are latched.
  - On mem_resp: d_resp=1 and d_rdata=mem_rdata in the same cycle, then go to DONE.
- DONE:
  - One cycle; mem_* requests are deasserted and no grant is made, so the requester can drop its request.
  - Always returns to IDLE.
- Latency:
  - Request seen in IDLE at cycle N gives mem_read/mem_write asserted at cycle N+1.
  - A response at cycle M means the next grant is decided at M+2 and issued to memory at M+3.
- Requests are latched at grant; later changes to requester inputs during a grant are ignored.
- Simultaneous d_read and d_write is illegal. The write wins, and `ifndef SYNTHESIS` an assertion fires.
- mem_resp while in IDLE or DONE is ignored: no resp is forwarded and no state change occurs.
- Only the owner ever sees resp; the non-owner's resp stays 0 and its request waits (no starvation bound without the macro).
- Reset mid-transaction:
  - State goes to IDLE next edge, mem_* drop and no resp is forwarded.
  - The adaptor is reset by the same rst.
- arb_busy = (state != IDLE), registered by construction.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit last_grant register, reset to D.
  - When I and D both request in IDLE, grant the requester that is not last_grant.
  - last_grant updates on every grant; single requests are granted unconditionally.
  - Each requester waits at most one foreign transaction.
- Undefined: fixed D-over-I priority and no last_grant register.

Test Plan:
- Isolated I read:
  - Stimulus: i_read=1, i_addr=0x0000_1040; mem_resp after 3 cycles with mem_rdata=0xA5..A5.
  - Required: mem_read=1 and mem_addr=0x1040 one cycle after request; i_resp pulses 1 cycle with i_rdata=0xA5..A5; d_resp stays 0; then DONE and IDLE.
- D writeback:
  - Stimulus: d_write=1, d_addr=0x8000_0200, d_wdata=0x1234..; mem_resp after 2 cycles.
  - Required: mem_write=1, mem_read=0, mem_wdata matches; d_resp one cycle.
- Conflict:
  - Stimulus: i_read and d_read rise in the same cycle.
  - Required without macro: D served first, then I granted 2 cycles after d_resp.
  - Required with ARB_ROUND_ROBIN_EN: the first conflict after reset grants I, and the next conflict grants D.
- Input change during grant:
  - Stimulus: in GRANT_D, change d_addr to 0xDEAD_0000 before mem_resp.
  - Required: mem_addr stays at the latched value.
- Reset mid-operation and stray response:
  - Stimulus: rst=1 during GRANT_I.
  - Required next cycle: mem_read=0, arb_busy=0, no i_resp.
  - Stimulus: mem_resp=1 while in IDLE.
  - Required: no resp forwarded and state stays IDLE.
